// File: rtl/umi_paced_device_port_if.sv
// UMI channel bundle: valid/ready handshake plus cmd/address/data fields.
// master drives valid and fields, slave drives ready.
interface umi_paced_device_port_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned AW = 64,
  parameter int unsigned CW = 32
);
  logic          valid;
  logic          ready;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;

  modport master (
    output valid, cmd, dstaddr, srcaddr, data,
    input  ready
  );

  modport slave (
    input  valid, cmd, dstaddr, srcaddr, data,
    output ready
  );
endinterface

// File: rtl/umi_paced_device_port.sv
// Paced UMI device port: FIFO-buffered request/response paths with
// run-time valid/ready pacing, transaction counters and outstanding tracking.
module umi_paced_device_port #(
  parameter int unsigned DW        = 256,
  parameter int unsigned AW        = 64,
  parameter int unsigned CW        = 32,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              valid_mode,
  input  logic [1:0]              ready_mode,
  umi_paced_device_port_if.slave  in_req,
  umi_paced_device_port_if.master umi_req,
  umi_paced_device_port_if.slave  umi_resp,
  umi_paced_device_port_if.master out_resp,
  output logic [31:0]             req_count,
  output logic [31:0]             resp_count,
  output logic [15:0]             outstanding
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = CW + 2 * AW + DW;

  typedef logic [PW:0] ptr_t;
  typedef enum logic {IDLE, PRESENT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    vmode_q, rmode_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          tgl_q;
  ptr_t          qwr_q, qrd_q, swr_q, srd_q;
  logic [EW-1:0] req_mem_q [DEPTH];
  logic [EW-1:0] resp_mem_q [DEPTH];
  logic [31:0]   reqc_q, reqc_d, respc_q, respc_d;
  logic [15:0]   outst_q, outst_d;

  logic req_full, req_empty, resp_full, resp_empty;
  logic req_push, req_pop, resp_push, resp_pop;
  logic vgate, rgate;
  ptr_t req_cnt;

  function automatic logic gate(input logic [1:0] m,
                                input logic r, input logic t);
    logic g;
    unique case (m)
      2'd0:    g = 1'b0;
      2'd1:    g = 1'b1;
      2'd2:    g = r;
      default: g = t;
    endcase
    return g;
  endfunction

  assign vgate = gate(vmode_q, lfsr_q[0], tgl_q);
  assign rgate = gate(rmode_q, lfsr_q[8], tgl_q);

  assign req_cnt   = qwr_q - qrd_q;
  assign req_empty = (qwr_q == qrd_q);
  assign req_full  = (qwr_q[PW] != qrd_q[PW]) &&
                     (qwr_q[PW-1:0] == qrd_q[PW-1:0]);
  assign resp_empty = (swr_q == srd_q);
  assign resp_full  = (swr_q[PW] != srd_q[PW]) &&
                      (swr_q[PW-1:0] == srd_q[PW-1:0]);

  assign in_req.ready = !req_full && !reset;
  assign req_push     = in_req.valid && in_req.ready;

  assign umi_req.valid = (state_q == PRESENT);
  assign {umi_req.cmd, umi_req.dstaddr, umi_req.srcaddr, umi_req.data} =
    umi_req.valid ? req_mem_q[qrd_q[PW-1:0]] : '0;

  assign umi_resp.ready = rgate && !resp_full && !reset;
  assign resp_push      = umi_resp.valid && umi_resp.ready;

  assign out_resp.valid = !resp_empty;
  assign {out_resp.cmd, out_resp.dstaddr, out_resp.srcaddr, out_resp.data} =
    resp_empty ? '0 : resp_mem_q[srd_q[PW-1:0]];
  assign resp_pop = out_resp.valid && out_resp.ready;

  assign req_count   = reqc_q;
  assign resp_count  = respc_q;
  assign outstanding = outst_q;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Presenter: a presented entry stays valid until the DUT accepts it.
  always_comb begin
    state_d = state_q;
    req_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!req_empty && vgate) state_d = PRESENT;
      end
      PRESENT: begin
        if (umi_req.ready) begin
          req_pop = 1'b1;
          state_d = (req_cnt > ptr_t'(1) && vgate) ? PRESENT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter next-state; outstanding saturates at both ends.
  always_comb begin
    reqc_d  = reqc_q + 32'(req_pop);
    respc_d = respc_q + 32'(resp_push);
    outst_d = outst_q;
    unique case ({req_pop, resp_push})
      2'b10:   if (outst_q != 16'hFFFF) outst_d = outst_q + 16'd1;
      2'b01:   if (outst_q != 16'h0000) outst_d = outst_q - 16'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Control state, pacing sources, pointers and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vmode_q <= 2'd0;
      rmode_q <= 2'd0;
      lfsr_q  <= LFSR_SEED;
      tgl_q   <= 1'b0;
      qwr_q   <= '0;
      qrd_q   <= '0;
      swr_q   <= '0;
      srd_q   <= '0;
      reqc_q  <= '0;
      respc_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      vmode_q <= valid_mode;
      rmode_q <= ready_mode;
      lfsr_q  <= lfsr_d;
      tgl_q   <= ~tgl_q;
      qwr_q   <= qwr_q + ptr_t'(req_push);
      qrd_q   <= qrd_q + ptr_t'(req_pop);
      swr_q   <= swr_q + ptr_t'(resp_push);
      srd_q   <= srd_q + ptr_t'(resp_pop);
      reqc_q  <= reqc_d;
      respc_q <= respc_d;
      outst_q <= outst_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (req_push)
      req_mem_q[qwr_q[PW-1:0]] <= {in_req.cmd, in_req.dstaddr,
                                   in_req.srcaddr, in_req.data};
    if (resp_push)
      resp_mem_q[swr_q[PW-1:0]] <= {umi_resp.cmd, umi_resp.dstaddr,
                                    umi_resp.srcaddr, umi_resp.data};
  end
endmodule
